// File: rtl/fetch_pkg.sv
// Shared types for the fetch unit: next-PC source selector and relative-offset width.
package fetch_pkg;

   localparam int REL_W = 8;

   typedef enum logic [2:0] {
      NPC_HOLD,
      NPC_INC,
      NPC_ABS,
      NPC_REL,
      NPC_CALL,
      NPC_RET
   } npc_sel_t;

endpackage

// File: rtl/fetch_unit_ret_stack.sv
// LIFO return-address stack; push when full and pop when empty are silently ignored.
module ret_stack
   import fetch_pkg::*;
#(
   parameter int D         = 10,
   parameter int STK_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [D-1:0] push_data,
   output logic [D-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int SPW = $clog2(STK_DEPTH + 1);
   localparam int IW  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

   logic [SPW-1:0] sp;
   logic [SPW-1:0] sp_m1;
   logic [D-1:0]   mem [STK_DEPTH];
   logic           do_push;
   logic           do_pop;

   assign full    = (sp == SPW'(STK_DEPTH));
   assign empty   = (sp == '0);
   assign sp_m1   = sp - SPW'(1);
   assign top     = mem[sp_m1[IW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && !full && !do_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp <= '0;
      end else if (do_pop) begin
         sp <= sp_m1;
      end else if (do_push) begin
         sp <= sp + SPW'(1);
      end
   end

   // Entry storage needs no reset: an empty stack pointer makes it unreachable.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[sp[IW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Program counter with jump table, relative jumps, stall and sticky done flag.
// Optional return stack (call/ret, stk_err) enabled by defining RET_STACK_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int D         = 10,
   parameter int LUT_AW    = 4,
   parameter int STK_DEPTH = 4,
   parameter int DONE_ADDR = 67
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              absjump_en,
   input  logic              reljump_en,
   input  logic              call_en,
   input  logic              ret_en,
   input  logic [LUT_AW-1:0] pc_immed,
   input  logic [REL_W-1:0]  rel_off,
   input  logic              lut_wr_en,
   input  logic [LUT_AW-1:0] lut_wr_addr,
   input  logic [D-1:0]      lut_wr_data,
   output logic [D-1:0]      prog_ctr,
   output logic              done,
   output logic              stk_err
);

   logic [D-1:0]        tbl [2**LUT_AW];
   logic [D-1:0]        tbl_rd;
   logic [D-1:0]        pc_inc;
   logic [D-1:0]        pc_rel;
   logic signed [D-1:0] rel_sext;
   logic                at_done;
   logic                call_q;
   logic                ret_q;
   logic                stk_full;
   logic                stk_empty;
   logic [D-1:0]        stk_top;
   logic                stk_push;
   logic                stk_pop;
   logic                err_set;
   npc_sel_t            npc_sel;

   // A same-cycle write to the index being read wins over the stored entry.
   assign tbl_rd   = (lut_wr_en && (lut_wr_addr == pc_immed)) ? lut_wr_data : tbl[pc_immed];
   assign pc_inc   = prog_ctr + D'(1);
   assign rel_sext = {{(D-REL_W){rel_off[REL_W-1]}}, rel_off};
   assign pc_rel   = prog_ctr + $unsigned(rel_sext);
   assign at_done  = done || (prog_ctr == D'(DONE_ADDR));

`ifdef RET_STACK_EN
   assign call_q = call_en;
   assign ret_q  = ret_en;

   ret_stack #(
      .D         (D),
      .STK_DEPTH (STK_DEPTH)
   ) u_ret_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (pc_inc),
      .top       (stk_top),
      .full      (stk_full),
      .empty     (stk_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stk_err <= 1'b0;
      end else if (err_set) begin
         stk_err <= 1'b1;
      end
   end
`else
   logic unused_stk;

   assign call_q     = 1'b0;
   assign ret_q      = 1'b0;
   assign stk_full   = 1'b1;
   assign stk_empty  = 1'b1;
   assign stk_top    = '0;
   assign stk_err    = 1'b0;
   assign unused_stk = &{1'b0, call_en, ret_en, stk_push, stk_pop, err_set};
`endif

   always_comb begin
      npc_sel  = NPC_INC;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      err_set  = 1'b0;
      if (at_done || stall) begin
         npc_sel = NPC_HOLD;
      end else if (ret_q) begin
         if (stk_empty) begin
            err_set = 1'b1;
         end else begin
            npc_sel = NPC_RET;
            stk_pop = 1'b1;
         end
      end else if (call_q) begin
         if (stk_full) begin
            err_set = 1'b1;
         end else begin
            npc_sel  = NPC_CALL;
            stk_push = 1'b1;
         end
      end else if (absjump_en) begin
         npc_sel = NPC_ABS;
      end else if (reljump_en) begin
         npc_sel = NPC_REL;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prog_ctr <= '0;
      end else begin
         case (npc_sel)
            NPC_HOLD: prog_ctr <= prog_ctr;
            NPC_ABS,
            NPC_CALL: prog_ctr <= tbl_rd;
            NPC_REL:  prog_ctr <= pc_rel;
            NPC_RET:  prog_ctr <= stk_top;
            default:  prog_ctr <= pc_inc;
         endcase
      end
   end

   // done latches the cycle after DONE_ADDR is seen; the PC is already held there.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
      end else if (prog_ctr == D'(DONE_ADDR)) begin
         done <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2**LUT_AW; i++) begin
            tbl[i] <= '0;
         end
      end else if (lut_wr_en) begin
         tbl[lut_wr_addr] <= lut_wr_data;
      end
   end

endmodule
